// File: rtl/cond_logic.sv
// Conditional-execution and NZCV status-flag unit for the single-cycle ARM-subset datapath.
// Evaluates Cond against the stored flags and gates the decoder's PC/register/memory write strobes.
module cond_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic       En,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic [3:0] Cond,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [1:0] r_nz;
  logic [1:0] r_cv;
  logic       w_cond_ex;
  logic       w_wr_nz;
  logic       w_wr_cv;

  // Odd encodings are the complement of the even encoding below them; AL
  // inverted becomes the reserved never-execute code 1111.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'b000:  base = z;
      3'b001:  base = c;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = c & ~z;
      3'b101:  base = ~(n ^ v);
      3'b110:  base = ~z & ~(n ^ v);
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  assign Flags     = {r_nz, r_cv};
  assign w_cond_ex = cond_pass(Cond, Flags);
  assign w_wr_nz   = En & w_cond_ex & FlagW[1];
  assign w_wr_cv   = En & w_cond_ex & FlagW[0];

  assign CondEx   = w_cond_ex;
  assign PCSrc    = PCS & w_cond_ex;
  assign RegWrite = RegW & w_cond_ex & ~NoWrite;
  assign MemWrite = MemW & w_cond_ex;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nz <= 2'b00;
      r_cv <= 2'b00;
    end else begin
      if (w_wr_nz) r_nz <= ALUFlags[3:2];
      if (w_wr_cv) r_cv <= ALUFlags[1:0];
    end
  end

endmodule
